// File: rtl/bus_pkg.sv
// Shared owner encoding and helpers for the registered bus source mux.
package bus_pkg;

  localparam int NUM_REGS_DEF = 8;
  localparam int DATA_W_DEF   = 16;
  localparam int CNT_W_DEF    = 8;
  localparam int SRC_MAX      = 32;

  function automatic int own_w(input int n_regs);
    return $clog2(n_regs + 5);
  endfunction

  function automatic int own_din(input int n_regs);
    return n_regs;
  endfunction

  function automatic int own_g(input int n_regs);
    return n_regs + 1;
  endfunction

  function automatic int own_zero(input int n_regs);
    return n_regs + 2;
  endfunction

  function automatic int own_one(input int n_regs);
    return n_regs + 3;
  endfunction

  function automatic logic [5:0] popcount(
    input logic [SRC_MAX-1:0] v
  );
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < SRC_MAX; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/bus_mux_reg_decode.sv
// Flattens all bus selects into one vector; returns the
// select count class, owner code and selected data.
module bus_sel_decode
  import bus_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int OWN_W    = own_w(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0]        Rout,
  input  logic [NUM_REGS*DATA_W-1:0] Rdata,
  input  logic                       DINout,
  input  logic [DATA_W-1:0]          DINdata,
  input  logic                       Gout,
  input  logic [DATA_W-1:0]          Gdata,
  input  logic                       Zout,
  input  logic                       Oneout,
  output logic                       n_is_one,
  output logic                       n_gt_one,
  output logic [OWN_W-1:0]           owner_code,
  output logic [DATA_W-1:0]          sel_data
);

  localparam int NSRC = NUM_REGS + 4;

  logic [NSRC-1:0]   sel_vec;
  logic [DATA_W-1:0] src [NSRC];
  logic [5:0]        n_sel;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      sel_vec[i] = Rout[NUM_REGS-1-i];
      src[i]     = Rdata[i*DATA_W +: DATA_W];
    end
    sel_vec[own_din(NUM_REGS)]  = DINout;
    sel_vec[own_g(NUM_REGS)]    = Gout;
    sel_vec[own_zero(NUM_REGS)] = Zout;
    sel_vec[own_one(NUM_REGS)]  = Oneout;
    src[own_din(NUM_REGS)]      = DINdata;
    src[own_g(NUM_REGS)]        = Gdata;
    src[own_zero(NUM_REGS)]     = '0;
    src[own_one(NUM_REGS)]      = {{(DATA_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    n_sel    = popcount(SRC_MAX'(sel_vec));
    n_is_one = (n_sel == 6'd1);
    n_gt_one = (n_sel > 6'd1);
  end

  // Only meaningful when exactly one select is set
  always_comb begin
    owner_code = '1;
    sel_data   = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel_vec[i]) begin
        owner_code = OWN_W'(i);
        sel_data   = src[i];
      end
    end
  end

endmodule

// File: rtl/bus_mux_reg.sv
// Registered bus source mux with owner tracking and
// saturating multi-select conflict counter.
module bus_mux_reg
  import bus_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int OWN_W    = own_w(NUM_REGS)
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  input  logic [NUM_REGS-1:0]        Rout,
  input  logic [NUM_REGS*DATA_W-1:0] Rdata,
  input  logic                       DINout,
  input  logic [DATA_W-1:0]          DINdata,
  input  logic                       Gout,
  input  logic [DATA_W-1:0]          Gdata,
  input  logic                       Zout,
  input  logic                       Oneout,
  input  logic                       clr_err,
  output logic [DATA_W-1:0]          BusWires,
  output logic                       bus_valid,
  output logic [OWN_W-1:0]           owner,
  output logic                       conflict,
  output logic                       err_sticky,
  output logic [CNT_W-1:0]           conflict_cnt
);

  logic              n_is_one;
  logic              n_gt_one;
  logic [OWN_W-1:0]  owner_code;
  logic [DATA_W-1:0] sel_data;

  logic [DATA_W-1:0] bus_q, bus_d;
  logic              valid_q, valid_d;
  logic [OWN_W-1:0]  owner_q, owner_d;
  logic              conflict_q, conflict_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_base;
  logic              sticky_base;

  bus_sel_decode #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .OWN_W    (OWN_W)
  ) u_dec (
    .Rout       (Rout),
    .Rdata      (Rdata),
    .DINout     (DINout),
    .DINdata    (DINdata),
    .Gout       (Gout),
    .Gdata      (Gdata),
    .Zout       (Zout),
    .Oneout     (Oneout),
    .n_is_one   (n_is_one),
    .n_gt_one   (n_gt_one),
    .owner_code (owner_code),
    .sel_data   (sel_data)
  );

  always_comb begin
    bus_d      = bus_q;
    owner_d    = owner_q;
    valid_d    = n_is_one;
    conflict_d = n_gt_one;
    if (n_is_one) begin
      bus_d   = sel_data;
      owner_d = owner_code;
    end
  end

  // Clear first, then count a conflict in the same cycle
  always_comb begin
    cnt_base    = clr_err ? '0 : cnt_q;
    sticky_base = clr_err ? 1'b0 : sticky_q;
    cnt_d       = cnt_base;
    sticky_d    = sticky_base;
    if (n_gt_one) begin
      sticky_d = 1'b1;
      if (cnt_base != '1) begin
        cnt_d = cnt_base + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      bus_q      <= '0;
      valid_q    <= 1'b0;
      owner_q    <= '1;
      conflict_q <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      bus_q      <= bus_d;
      valid_q    <= valid_d;
      owner_q    <= owner_d;
      conflict_q <= conflict_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  assign BusWires     = bus_q;
  assign bus_valid    = valid_q;
  assign owner        = owner_q;
  assign conflict     = conflict_q;
  assign err_sticky   = sticky_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed bench for bus_mux_reg; a second instance with a
// 2-bit counter covers saturation.
module tb_bus_mux_reg;

  logic         clk;
  logic         rstn;
  logic [7:0]   rout;
  logic [127:0] rdata;
  logic         din_out;
  logic [15:0]  din_data;
  logic         g_out;
  logic [15:0]  g_data;
  logic         z_out;
  logic         one_out;
  logic         clr;

  logic [15:0]  bus_a, bus_b;
  logic         val_a, val_b;
  logic [3:0]   own_a, own_b;
  logic         cf_a, cf_b;
  logic         st_a, st_b;
  logic [7:0]   cnt_a;
  logic [1:0]   cnt_b;

  int n_cmp;
  int n_bad;

  bus_mux_reg dut (
    .Clock        (clk),
    .Resetn       (rstn),
    .Rout         (rout),
    .Rdata        (rdata),
    .DINout       (din_out),
    .DINdata      (din_data),
    .Gout         (g_out),
    .Gdata        (g_data),
    .Zout         (z_out),
    .Oneout       (one_out),
    .clr_err      (clr),
    .BusWires     (bus_a),
    .bus_valid    (val_a),
    .owner        (own_a),
    .conflict     (cf_a),
    .err_sticky   (st_a),
    .conflict_cnt (cnt_a)
  );

  bus_mux_reg #(.CNT_W(2)) dut2 (
    .Clock        (clk),
    .Resetn       (rstn),
    .Rout         (rout),
    .Rdata        (rdata),
    .DINout       (din_out),
    .DINdata      (din_data),
    .Gout         (g_out),
    .Gdata        (g_data),
    .Zout         (z_out),
    .Oneout       (one_out),
    .clr_err      (clr),
    .BusWires     (bus_b),
    .bus_valid    (val_b),
    .owner        (own_b),
    .conflict     (cf_b),
    .err_sticky   (st_b),
    .conflict_cnt (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic no_sel();
    rout    = 8'h00;
    din_out = 1'b0;
    g_out   = 1'b0;
    z_out   = 1'b0;
    one_out = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic test_reset();
    no_sel();
    rstn = 1'b0;
    rout = 8'h80;
    step();
    step();
    n_cmp++;
    if (bus_a !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_bus got %h want 0000", bus_a);
    end
    n_cmp++;
    if (own_a !== 4'hF) begin
      n_bad++;
      $display("FAIL reset_owner got %h want f", own_a);
    end
    n_cmp++;
    if (val_a !== 1'b0 || cf_a !== 1'b0 || st_a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags got v%b c%b s%b want 000",
               val_a, cf_a, st_a);
    end
    n_cmp++;
    if (cnt_a !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_cnt got %0d want 0", cnt_a);
    end
    rstn = 1'b1;
    no_sel();
  endtask

  task automatic test_each_source();
    logic [15:0] exp_d [12];
    logic [3:0]  exp_o [12];
    for (int i = 0; i < 8; i++) begin
      rdata[i*16 +: 16] = 16'h1000 + 16'(i);
      exp_d[i] = 16'h1000 + 16'(i);
      exp_o[i] = 4'(i);
    end
    din_data = 16'hBEEF;
    g_data   = 16'h00AA;
    exp_d[8] = 16'hBEEF;  exp_o[8]  = 4'd8;
    exp_d[9] = 16'h00AA;  exp_o[9]  = 4'd9;
    exp_d[10] = 16'h0000; exp_o[10] = 4'd10;
    exp_d[11] = 16'h0001; exp_o[11] = 4'd11;
    for (int k = 0; k < 12; k++) begin
      no_sel();
      if (k < 8) rout = 8'h80 >> k;
      din_out = (k == 8);
      g_out   = (k == 9);
      z_out   = (k == 10);
      one_out = (k == 11);
      step();
      n_cmp++;
      if (bus_a !== exp_d[k] || own_a !== exp_o[k]
          || val_a !== 1'b1) begin
        n_bad++;
        $display("FAIL src[%0d] got %h/%h/%b want %h/%h/1",
                 k, bus_a, own_a, val_a, exp_d[k], exp_o[k]);
      end
    end
    no_sel();
  endtask

  task automatic test_idle_hold();
    rout = 8'h10;
    step();
    rout = 8'h00;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (bus_a !== 16'h1003 || own_a !== 4'd3
          || val_a !== 1'b0) begin
        n_bad++;
        $display("FAIL idle[%0d] got %h/%h/%b want 1003/3/0",
                 k, bus_a, own_a, val_a);
      end
    end
  endtask

  task automatic test_conflict();
    rout  = 8'h80;
    g_out = 1'b1;
    step();
    no_sel();
    n_cmp++;
    if (bus_a !== 16'h1003 || own_a !== 4'd3 || val_a !== 1'b0) begin
      n_bad++;
      $display("FAIL conf_hold got %h/%h/%b want 1003/3/0",
               bus_a, own_a, val_a);
    end
    n_cmp++;
    if (cf_a !== 1'b1 || st_a !== 1'b1 || cnt_a !== 8'd1) begin
      n_bad++;
      $display("FAIL conf_flags got c%b s%b n%0d want c1 s1 n1",
               cf_a, st_a, cnt_a);
    end
    step();
    n_cmp++;
    if (cf_a !== 1'b0 || st_a !== 1'b1 || cnt_a !== 8'd1) begin
      n_bad++;
      $display("FAIL conf_after got c%b s%b n%0d want c0 s1 n1",
               cf_a, st_a, cnt_a);
    end
  endtask

  task automatic test_saturate_clear();
    logic [1:0] exp_b [5];
    exp_b = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      no_sel();
      z_out   = 1'b1;
      one_out = 1'b1;
      step();
      n_cmp++;
      if (cnt_b !== exp_b[k] || cnt_a !== 8'(k + 1)) begin
        n_bad++;
        $display("FAIL sat[%0d] got %0d/%0d want %0d/%0d",
                 k, cnt_b, cnt_a, exp_b[k], k + 1);
      end
    end
    no_sel();
    clr = 1'b1;
    step();
    n_cmp++;
    if (cnt_b !== 2'd0 || st_b !== 1'b0
        || cnt_a !== 8'd0 || st_a !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_only got %0d/%b %0d/%b want 0/0 0/0",
               cnt_b, st_b, cnt_a, st_a);
    end
    din_out = 1'b1;
    g_out   = 1'b1;
    step();
    n_cmp++;
    if (cnt_b !== 2'd1 || st_b !== 1'b1
        || cnt_a !== 8'd1 || st_a !== 1'b1 || cf_b !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_conf got %0d/%b %0d/%b want 1/1 1/1",
               cnt_b, st_b, cnt_a, st_a);
    end
    no_sel();
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [4];
    vals = '{16'h0F0F, 16'hF0F0, 16'h1234, 16'hFFFF};
    din_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din_data = vals[k];
      step();
      n_cmp++;
      if (bus_a !== vals[k] || own_a !== 4'd8 || val_a !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b[%0d] got %h/%h want %h/8",
                 k, bus_a, own_a, vals[k]);
      end
    end
    no_sel();
  endtask

  task automatic test_mid_reset();
    din_out  = 1'b1;
    din_data = 16'hCAFE;
    clr      = 1'b0;
    rstn     = 1'b0;
    step();
    n_cmp++;
    if (bus_a !== 16'h0000 || own_a !== 4'hF || val_a !== 1'b0
        || st_a !== 1'b0 || cnt_a !== 8'd0) begin
      n_bad++;
      $display("FAIL midrst got %h/%h/%b/%b/%0d want 0/f/0/0/0",
               bus_a, own_a, val_a, st_a, cnt_a);
    end
    rstn     = 1'b1;
    din_data = 16'h5678;
    step();
    n_cmp++;
    if (bus_a !== 16'h5678 || own_a !== 4'd8 || val_a !== 1'b1) begin
      n_bad++;
      $display("FAIL post_rst got %h/%h/%b want 5678/8/1",
               bus_a, own_a, val_a);
    end
    no_sel();
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rstn     = 1'b0;
    rdata    = '0;
    din_data = '0;
    g_data   = '0;
    no_sel();
    #1;
    test_reset();
    test_each_source();
    test_idle_hold();
    test_conflict();
    test_saturate_clear();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
